counter_scheduler: RTL

Time-shares one external 8-bit enable/clear up-counter among NREQ requesters, each wanting a counted interval of its own length. Arbitrates pending requests, clears the counter, enables it until the winner's terminal value is reached, and then returns a one-cycle done pulse to that requester. Sits between the requesting control blocks and a single up_counter instance. The counter's `reset` input is driven by `cnt_clr`, its `enable` input by `cnt_en`, and its `out` is fed back as `cnt_val`.

---
 rtl/counter_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/counter_scheduler.sv
// Time-shares one external enable/clear up-counter among NREQ requesters.
// SCHED_RR_EN selects round-robin arbitration; otherwise the lowest index wins.
module counter_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  input  logic [WIDTH-1:0]      cnt_val,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  abort,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [IW-1:0]    owner;
  logic [WIDTH-1:0] lim_q;
  logic [IW-1:0]    win;
  logic             any;
  logic             req_own;
  logic             hit;

`ifdef SCHED_RR_EN
  logic [IW-1:0]    ptr;
`endif

  // First active request in search order; round-robin starts after ptr.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
`ifdef SCHED_RR_EN
      idx = (int'(ptr) + 1 + k) % NREQ;
`else
      idx = k;
`endif
      if (!any && req[idx[IW-1:0]]) begin
        any = 1'b1;
        win = idx[IW-1:0];
      end
    end
  end

  assign req_own = req[owner];
  assign hit     = (cnt_val == lim_q);
  assign busy    = (state != IDLE);
  // Abort overrides both the clear and the terminal-count check.
  assign abort   = ((state == CLEAR) || (state == RUN)) && !req_own;
  assign cnt_clr = (state == CLEAR) && req_own;
  assign cnt_en  = (state == RUN) && req_own && !hit;

  always_comb begin
    grant = '0;
    done  = '0;
    if (busy)          grant[owner] = 1'b1;
    if (state == DONE) done[owner]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= '0;
      lim_q <= '0;
`ifdef SCHED_RR_EN
      ptr   <= IW'(NREQ - 1);
`endif
    end else begin
      case (state)
        IDLE: if (any) begin
          state <= CLEAR;
          owner <= win;
          lim_q <= limit[int'(win)*WIDTH +: WIDTH];
`ifdef SCHED_RR_EN
          ptr   <= win;
`endif
        end
        CLEAR: state <= abort ? IDLE : RUN;
        RUN: begin
          if (abort)    state <= IDLE;
          else if (hit) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
